// File: rtl/modulo_inverse_if.sv
// Start/finished handshake bundle shared by the ECC datapath units:
// operands and width select in, result and status out.
interface modulo_inverse_if #(parameter int W = 256);
  logic         i_start;
  logic [1:0]   i_mode;
  logic [W-1:0] i_n;
  logic [W-1:0] i_a;
  logic [W-1:0] o_result;
  logic         o_finished;
  logic         o_error;
  logic         o_busy;

  modport master (
    output i_start, i_mode, i_n, i_a,
    input  o_result, o_finished, o_error, o_busy
  );

  modport slave (
    input  i_start, i_mode, i_n, i_a,
    output o_result, o_finished, o_error, o_busy
  );
endinterface

// File: rtl/modulo_inverse.sv
// Modular inverse a^-1 mod n via the binary extended Euclidean algorithm,
// one reduction step per clock.
module modulo_inverse #(parameter int W = 256) (
  input logic            i_clk,
  input logic            i_rst,
  modulo_inverse_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;

  state_t       state, next_state;
  logic [W-1:0] a_reg, n_reg, u, v, x1, x2, result;
  logic         error;
  logic [W-1:0] mode_mask;
  logic [W:0]   x1_sum, x2_sum;
  logic [W-1:0] x1_half, x2_half, x1_sub, x2_sub;
  logic         operands_bad, run_end;

  // i_mode codes 0..3 select 32/64/128/256-bit operands
  always_comb begin
    mode_mask = {W{1'b1}} >> (W - (32 << bus.i_mode));
  end

  // Halving keeps x in [0,n): odd x gets n added first, at W+1 bits
  always_comb begin
    x1_sum  = {1'b0, x1} + {1'b0, n_reg};
    x2_sum  = {1'b0, x2} + {1'b0, n_reg};
    x1_half = x1[0] ? x1_sum[W:1] : (x1 >> 1);
    x2_half = x2[0] ? x2_sum[W:1] : (x2 >> 1);
    x1_sub  = (x1 >= x2) ? (x1 - x2) : (x1 - x2 + n_reg);
    x2_sub  = (x2 >= x1) ? (x2 - x1) : (x2 - x1 + n_reg);
    operands_bad = !n_reg[0] || (n_reg <= W'(1)) || (a_reg == '0) || (a_reg >= n_reg);
    run_end = (u == W'(1)) || (v == W'(1)) || (u == '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.i_start) next_state = CHECK;
      CHECK:   next_state = operands_bad ? DONE : RUN;
      RUN:     if (run_end) next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath; the RUN branch order is the step priority of the algorithm
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_reg  <= '0;
      n_reg  <= '0;
      u      <= '0;
      v      <= '0;
      x1     <= '0;
      x2     <= '0;
      result <= '0;
      error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            a_reg  <= bus.i_a & mode_mask;
            n_reg  <= bus.i_n & mode_mask;
            result <= '0;
            error  <= 1'b0;
          end
        end
        CHECK: begin
          if (operands_bad) begin
            error <= 1'b1;
          end else begin
            u  <= a_reg;
            v  <= n_reg;
            x1 <= W'(1);
            x2 <= '0;
          end
        end
        RUN: begin
          if (u == W'(1)) begin
            result <= x1;
          end else if (v == W'(1)) begin
            result <= x2;
          end else if (u == '0) begin
            error  <= 1'b1;
            result <= '0;
          end else if (!u[0]) begin
            u  <= u >> 1;
            x1 <= x1_half;
          end else if (!v[0]) begin
            v  <= v >> 1;
            x2 <= x2_half;
          end else if (u >= v) begin
            u  <= u - v;
            x1 <= x1_sub;
          end else begin
            v  <= v - u;
            x2 <= x2_sub;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_result   = result;
    bus.o_error    = error;
    bus.o_finished = (state == DONE);
    bus.o_busy     = (state == CHECK) || (state == RUN);
  end

endmodule

// File: tb/tb_modulo_inverse.sv
// Self-checking bench for modulo_inverse: directed cases plus random operands
// compared against an extended-Euclid reference model.
module tb_modulo_inverse;
  localparam int W = 256;
  localparam logic [1:0] MODE32 = 2'd0, MODE64 = 2'd1, MODE256 = 2'd3;
  localparam logic [W-1:0] P256 =
    256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

  logic i_clk = 1'b0;
  logic i_rst;

  modulo_inverse_if #(.W(W)) bus ();
  modulo_inverse #(.W(W)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] got_result;
  logic got_error, got_done, busy_ok, pulse_ok;
  int got_lat;

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mask_of(input logic [1:0] m);
    return {W{1'b1}} >> (W - (32 << m));
  endfunction

  // Classic extended Euclid with division; coefficients tracked mod n
  function automatic void ref_inverse(input logic [W-1:0] a, input logic [W-1:0] n,
                                      output logic [W-1:0] res, output logic err);
    logic [2*W-1:0] r0, r1, t0, t1, q, tmp, nn;
    res = '0;
    err = (n[0] == 1'b0) || (n <= W'(1)) || (a == '0) || (a >= n);
    if (err) return;
    nn = {{W{1'b0}}, n};
    r0 = nn;
    r1 = {{W{1'b0}}, a};
    t0 = '0;
    t1 = 1;
    while (r1 != 0) begin
      q   = r0 / r1;
      tmp = r0 - q * r1;
      r0  = r1;
      r1  = tmp;
      tmp = (t0 + nn - ((q * t1) % nn)) % nn;
      t0  = t1;
      t1  = tmp;
    end
    if (r0 != 1) err = 1'b1;
    else         res = t0[W-1:0];
  endfunction

  // Latency counts the cycle presenting i_start as cycle 1
  task automatic applyStimulus(input logic [1:0] mode, input logic [W-1:0] n,
                               input logic [W-1:0] a, input bit disturb);
    int bound;
    bound = 3 * (32 << mode) + 4;
    @(negedge i_clk);
    bus.i_mode  = mode;
    bus.i_n     = n;
    bus.i_a     = a;
    bus.i_start = 1'b1;
    got_lat  = 1;
    got_done = 1'b0;
    busy_ok  = 1'b1;
    got_result = '0;
    got_error  = 1'b0;
    while (!got_done && got_lat <= bound + 4) begin
      @(posedge i_clk);
      #1;
      got_lat++;
      bus.i_start = 1'b0;
      if (got_lat == 2) begin
        bus.i_mode = ~mode;
        bus.i_n    = ~n;
        bus.i_a    = ~a;
      end
      if (disturb && got_lat == 3) bus.i_start = 1'b1;
      if (bus.o_finished === 1'b1) begin
        got_done   = 1'b1;
        got_result = bus.o_result;
        got_error  = bus.o_error;
        if (bus.o_busy !== 1'b0) busy_ok = 1'b0;
      end else if (bus.o_busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
    bus.i_start = 1'b0;
    @(posedge i_clk);
    #1;
    pulse_ok = (bus.o_finished === 1'b0) && (bus.o_result === got_result) &&
               (bus.o_error === got_error) && (bus.o_busy === 1'b0);
  endtask

  task automatic checkRun(input string tag, input logic [1:0] mode,
                          input logic [W-1:0] n, input logic [W-1:0] a);
    logic [W-1:0] exp_res, m;
    logic exp_err;
    m = mask_of(mode);
    ref_inverse(a & m, n & m, exp_res, exp_err);
    checkOutput({tag, ".done"},    W'(got_done), W'(1));
    checkOutput({tag, ".error"},   W'(got_error), W'(exp_err));
    checkOutput({tag, ".result"},  got_result, exp_res);
    checkOutput({tag, ".latency"}, W'(got_lat <= 3 * (32 << mode) + 4), W'(1));
    checkOutput({tag, ".busy"},    W'(busy_ok), W'(1));
    checkOutput({tag, ".pulse"},   W'(pulse_ok), W'(1));
  endtask

  initial begin
    logic [W-1:0] rn, ra, m;
    logic [1:0] rmode;
    logic seen_fin;

    i_rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_mode  = MODE32;
    bus.i_n     = '0;
    bus.i_a     = '0;
    #12;
    checkOutput("reset.result",   bus.o_result, '0);
    checkOutput("reset.finished", W'(bus.o_finished), '0);
    checkOutput("reset.error",    W'(bus.o_error), '0);
    checkOutput("reset.busy",     W'(bus.o_busy), '0);
    @(negedge i_clk);
    i_rst = 1'b0;

    applyStimulus(MODE32, 23, 5, 0);
    checkRun("n23a5", MODE32, 23, 5);
    checkOutput("n23a5.value", got_result, 14);
    checkOutput("n23a5.lat100", W'(got_lat <= 100), W'(1));

    applyStimulus(MODE32, 13, 1, 0);
    checkRun("a1", MODE32, 13, 1);
    checkOutput("a1.value", got_result, 1);
    checkOutput("a1.cycles", W'(got_lat), 4);

    applyStimulus(MODE32, 21, 6, 0);
    checkRun("gcd3", MODE32, 21, 6);
    checkOutput("gcd3.error", W'(got_error), 1);
    applyStimulus(MODE32, 23, 0, 0);
    checkRun("a0", MODE32, 23, 0);
    checkOutput("a0.error", W'(got_error), 1);
    applyStimulus(MODE32, 24, 5, 0);
    checkRun("neven", MODE32, 24, 5);
    checkOutput("neven.error", W'(got_error), 1);
    applyStimulus(MODE32, 23, 30, 0);
    checkRun("abig", MODE32, 23, 30);
    checkOutput("abig.error", W'(got_error), 1);

    applyStimulus(MODE256, P256, 2, 0);
    checkRun("p256", MODE256, P256, 2);
    checkOutput("p256.value", got_result, W'(({1'b0, P256} + 1) >> 1));

    applyStimulus(MODE32, 23, 5, 1);
    checkRun("restart", MODE32, 23, 5);
    checkOutput("restart.value", got_result, 14);

    // Junk above the 64-bit width must be stripped before inversion
    ra = W'(64'h0123_4567_89AB_CDEF) | (W'(1) << 100) | (W'(1) << 200);
    rn = W'(64'hFFFF_FFFF_FFFF_FFC5);
    applyStimulus(MODE64, rn, ra, 0);
    checkRun("mask64", MODE64, rn, ra);

    for (int i = 0; i < 16; i++) begin
      rmode = (i == 15) ? MODE256 : 2'($urandom_range(0, 2));
      m = mask_of(rmode);
      for (int k = 0; k < 8; k++) begin
        rn[k*32 +: 32] = $urandom;
        ra[k*32 +: 32] = $urandom;
      end
      rn = (rn & m) | W'(3);
      ra = (ra & m) % rn;
      if (ra == '0) ra = W'(1);
      ra = ra | ({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom} & ~m);
      applyStimulus(rmode, rn, ra, 0);
      checkRun($sformatf("rand%0d", i), rmode, rn, ra);
    end

    @(negedge i_clk);
    bus.i_mode  = MODE256;
    bus.i_n     = P256;
    bus.i_a     = 3;
    bus.i_start = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_start = 1'b0;
    repeat (6) @(posedge i_clk);
    #3;
    i_rst = 1'b1;
    #1;
    checkOutput("abort.result",   bus.o_result, '0);
    checkOutput("abort.finished", W'(bus.o_finished), '0);
    checkOutput("abort.error",    W'(bus.o_error), '0);
    checkOutput("abort.busy",     W'(bus.o_busy), '0);
    @(negedge i_clk);
    i_rst = 1'b0;
    seen_fin = 1'b0;
    repeat (8) begin
      @(posedge i_clk);
      #1;
      if (bus.o_finished === 1'b1) seen_fin = 1'b1;
    end
    checkOutput("abort.nofinish", W'(seen_fin), '0);
    applyStimulus(MODE32, 23, 5, 0);
    checkRun("after_abort", MODE32, 23, 5);
    checkOutput("after_abort.value", got_result, 14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/modulo_inverse.md
Name: modulo_inverse

Overview:
- Computes o_result = i_a^-1 mod i_n using the binary extended Euclidean algorithm, one step per clock.
- It is the inverse-direction companion to the shift-and-add modular multiplier in the ECC datapath. The point-arithmetic controller uses it for field division (affine conversion, slope computation).
- Shares the multiplier's start/finished handshake and the i_mode width select from ECCDefine.vh.

Parameters:
W, `MAX_BITS (256), datapath width; all operand/result ports are W bits.

Ports:
i_clk  input  1  clock.
i_rst  input  1  reset, asynchronous, active-high.
i_start  input  1  start pulse; sampled only in IDLE.
i_mode  input  2  `BITS32/`BITS64/`BITS128/`BITS256 operand width select.
i_n  input  W  modulus; must be odd, > 1.
i_a  input  W  value to invert; must satisfy 0 < a < n.
o_result  output  W  inverse; valid when o_finished pulses, held until next accepted start.
o_finished  output  1  one-cycle pulse at completion.
o_error  output  1  set with o_finished when no inverse exists / illegal operands; held until next accepted start.
o_busy  output  1  high from the cycle after an accepted start until the cycle o_finished rises.

Behaviour:
- Reset (async, i_rst=1): state IDLE; o_result=0, o_finished=0, o_error=0, o_busy=0; internal u,v,x1,x2 cleared. Reset mid-operation aborts with no o_finished pulse.
- Mode masking: i_a and i_n are masked to the mode width (31/63/127/255 MSB index) at start. o_result bits above the mode width are always 0. i_mode is sampled at start; later changes are ignored.
- States: IDLE -> CHECK -> RUN -> DONE -> IDLE.
- IDLE:
  - i_start=1 captures masked a, n into registers.
  - On the same edge o_error and o_result are cleared, and the state moves to CHECK.
  - i_start while not IDLE is ignored.
- CHECK (1 cycle):
  - If n even, n<=1, a==0, or a>=n: o_error=1 and go to DONE.
  - Otherwise load u=a, v=n, x1=1, x2=0 and go to RUN.
- RUN: exactly one action per cycle, in this priority:
  1. u==1: o_result=x1, go to DONE.
  2. v==1: o_result=x2, go to DONE.
  3. u==0: o_error=1, o_result=0, go to DONE (gcd≠1).
  4. u even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+n)>>1.
  5. v even: v=v>>1; x2 is updated by the same rule.
  6. u>=v: u=u-v; x1 = x1>=x2 ? x1-x2 : x1-x2+n.
  7. Otherwise: v=v-u; x2 = x2>=x1 ? x2-x1 : x2-x1+n.
- Arithmetic:
  - x1+n is computed at W+1 bits before the shift; no overflow is permitted.
  - x1, x2 stay in [0,n) at all times.
  - Comparisons are unsigned.
- DONE (1 cycle): o_finished=1, o_busy=0, return to IDLE. o_finished is registered, so it is high exactly one cycle after the terminating RUN decision. Back-to-back start is accepted in the IDLE cycle following DONE.
- Latency: start-to-o_finished is at most 3*B+4 cycles, where B is the mode width (32/64/128/256). The bench must flag any exceedance.
- Result is canonical: 0 < o_result < n and (a*o_result) mod n == 1 whenever o_error=0.

Test Plan:
- `BITS32, n=23, a=5, start -> o_finished pulse, o_result=14, o_error=0, latency ≤ 100 cycles; o_busy high throughout.
- `BITS32, n=13, a=1 -> o_result=1 in the first RUN cycle; total latency 4 cycles from start edge to o_finished.
- Errors:
  - n=21, a=6 (gcd 3) -> o_error=1, o_result=0.
  - a=0 -> o_error=1 from CHECK.
  - n=24 -> o_error=1 from CHECK.
  - a=30, n=23 -> o_error=1 from CHECK.
- `BITS256, n=P-256 prime (FFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF), a=2 -> o_result=(n+1)/2; latency ≤ 772.
- Protocol:
  - Second i_start pulse while busy -> ignored, first result unchanged.
  - Change i_mode mid-run -> no effect.
  - Bits of i_a above the `BITS64 width set -> masked; result equals the inverse of the masked value.
- Reset: assert i_rst mid-RUN asynchronously -> all outputs 0 immediately, no o_finished. A new start after release gives a correct result (n=23, a=5 -> 14).
